// File: rtl/strength_bus_arbiter_if.sv
// Bus bundle for strength_bus_arbiter: strength-tagged requests in,
// resolved shared net and ownership status out.
interface strength_bus_arbiter_if #(
  parameter int N = 4,
  parameter int W = 100
);
  logic [N-1:0]   req;
  logic [3*N-1:0] strength;
  logic [W*N-1:0] data;
  logic [N-1:0]   grant;
  logic [W-1:0]   bus_out;
  logic [2:0]     bus_strength;
  logic           bus_valid;
  logic           tie;

  // Sources side: drives requests, strengths and drive values.
  modport master (
    output req, strength, data,
    input  grant, bus_out, bus_strength, bus_valid, tie
  );

  // Arbiter side.
  modport slave (
    input  req, strength, data,
    output grant, bus_out, bus_strength, bus_valid, tie
  );
endinterface

// File: rtl/strength_bus_arbiter.sv
// strength_bus_arbiter: clocked resolution of a multi-driver net.
// The strongest requester owns the bus, ties go round-robin from rr_ptr,
// and the net falls back to DEFAULT at weak strength when nobody owns it.
// Optional macro STRENGTH_PREEMPT_EN: a strictly stronger candidate takes
// the bus from the owner through a one-cycle HANDOVER gap. Without it the
// owner keeps the bus until it drops req or its strength falls to 0.
module strength_bus_arbiter #(
  parameter int             N       = 4,
  parameter int             W       = 100,
  parameter logic [W-1:0]   DEFAULT = {W{1'b0}}
) (
  input logic                    clk,
  input logic                    rst,
  strength_bus_arbiter_if.slave  bus
);

  localparam int IDX = (N > 1) ? $clog2(N) : 1;

`ifdef STRENGTH_PREEMPT_EN
  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_OWNED    = 2'd1,
    ST_HANDOVER = 2'd2
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_OWNED = 2'd1
  } state_e;
`endif

  // Supply levels 4..7 all collapse to 4.
  function automatic logic [2:0] eff_of(input logic [2:0] s);
    logic [2:0] r;
    if (s > 3'd4) begin
      r = 3'd4;
    end else begin
      r = s;
    end
    return r;
  endfunction

  state_e         state_q, state_d;
  logic [N-1:0]   grant_q, grant_d;
  logic [IDX-1:0] rr_ptr_q, rr_ptr_d;
  logic           tie_q, tie_d;

  logic [2:0]     eff_s [N];
  logic [N-1:0]   cand_s;
  logic [N-1:0]   top_s;
  logic [2:0]     max_s;
  int             top_cnt_s;
  int             dist_s;
  int             best_dist_s;
  logic [IDX-1:0] win_idx_s;
  logic           any_cand_s;
  logic           owner_live_s;
  logic [2:0]     owner_eff_s;
  logic [W-1:0]   bus_out_s;
  logic [2:0]     bus_strength_s;

  // Effective strength and candidacy of every requester.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      eff_s[i]  = eff_of(bus.strength[i*3 +: 3]);
      cand_s[i] = bus.req[i] && (eff_s[i] != 3'd0);
    end
  end

  // Strongest level among candidates and the set sitting at that level.
  always_comb begin
    max_s     = 3'd0;
    top_cnt_s = 0;
    top_s     = {N{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (cand_s[i] && (eff_s[i] > max_s)) begin
        max_s = eff_s[i];
      end else begin
        max_s = max_s;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (cand_s[i] && (eff_s[i] == max_s)) begin
        top_s[i]  = 1'b1;
        top_cnt_s = top_cnt_s + 1;
      end else begin
        top_s[i]  = 1'b0;
      end
    end
  end

  // Round-robin pick: the top-level candidate closest at or after rr_ptr.
  always_comb begin
    best_dist_s = N;
    dist_s      = 0;
    win_idx_s   = {IDX{1'b0}};
    for (int i = 0; i < N; i++) begin
      if (i >= int'(rr_ptr_q)) begin
        dist_s = i - int'(rr_ptr_q);
      end else begin
        dist_s = i + N - int'(rr_ptr_q);
      end
      if (top_s[i] && (dist_s < best_dist_s)) begin
        best_dist_s = dist_s;
        win_idx_s   = IDX'(i);
      end else begin
        best_dist_s = best_dist_s;
      end
    end
    any_cand_s = |cand_s;
  end

  // Current owner's liveness and effective strength, read through the grant.
  always_comb begin
    owner_live_s = |(grant_q & cand_s);
    owner_eff_s  = 3'd0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        owner_eff_s = eff_s[i];
      end else begin
        owner_eff_s = owner_eff_s;
      end
    end
  end

  // Next-state logic: arbitration, hold, drop-through and handover.
  always_comb begin
    state_d  = state_q;
    grant_d  = grant_q;
    rr_ptr_d = rr_ptr_q;
    tie_d    = 1'b0;
    case (state_q)
      ST_OWNED: begin
        if (owner_live_s) begin
`ifdef STRENGTH_PREEMPT_EN
          if (max_s > owner_eff_s) begin
            state_d = ST_HANDOVER;
            grant_d = {N{1'b0}};
          end else begin
            state_d = ST_OWNED;
          end
`else
          state_d = ST_OWNED;
`endif
        end else if (any_cand_s) begin
          state_d  = ST_OWNED;
          grant_d  = {{(N-1){1'b0}}, 1'b1} << win_idx_s;
          rr_ptr_d = (win_idx_s == IDX'(N-1)) ? {IDX{1'b0}} : win_idx_s + IDX'(1);
          tie_d    = (top_cnt_s > 1);
        end else begin
          state_d = ST_IDLE;
          grant_d = {N{1'b0}};
        end
      end
      default: begin
        // IDLE and HANDOVER both arbitrate afresh on this edge.
        if (any_cand_s) begin
          state_d  = ST_OWNED;
          grant_d  = {{(N-1){1'b0}}, 1'b1} << win_idx_s;
          rr_ptr_d = (win_idx_s == IDX'(N-1)) ? {IDX{1'b0}} : win_idx_s + IDX'(1);
          tie_d    = (top_cnt_s > 1);
        end else begin
          state_d = ST_IDLE;
          grant_d = {N{1'b0}};
        end
      end
    endcase
  end

  // State, grant, round-robin pointer and tie flag registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= {N{1'b0}};
      rr_ptr_q <= {IDX{1'b0}};
      tie_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      rr_ptr_q <= rr_ptr_d;
      tie_q    <= tie_d;
    end
  end

  // Resolved net: owner's slice and live strength, or the weak default.
  always_comb begin
    bus_out_s      = DEFAULT;
    bus_strength_s = 3'd1;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        bus_out_s      = bus.data[i*W +: W];
        bus_strength_s = eff_s[i];
      end else begin
        bus_out_s      = bus_out_s;
        bus_strength_s = bus_strength_s;
      end
    end
  end

  assign bus.grant        = grant_q;
  assign bus.bus_valid    = (state_q == ST_OWNED);
  assign bus.tie          = tie_q;
  assign bus.bus_out      = bus_out_s;
  assign bus.bus_strength = bus_strength_s;

endmodule

// File: tb/tb_strength_bus_arbiter.sv
// Self-checking bench for strength_bus_arbiter: directed scenarios followed
// by randomized traffic, all compared against a behavioural ownership model.
module tb_strength_bus_arbiter;
  localparam int N = 4;
  localparam int W = 100;
  localparam logic [W-1:0] DEF = {W{1'b0}};

  logic clk;
  logic rst;
  int   tests;
  int   fails;

  // Reference model state.
  int m_owner;
  int m_rr;
  bit m_tie;

  strength_bus_arbiter_if #(.N(N), .W(W)) bus_if ();

  strength_bus_arbiter #(.N(N), .W(W), .DEFAULT(DEF)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus_if)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int effs(int i);
    int s;
    s = int'(bus_if.strength[i*3 +: 3]);
    return (s > 4) ? 4 : s;
  endfunction

  function automatic bit is_cand(int i);
    return bus_if.req[i] && (effs(i) > 0);
  endfunction

  task automatic model_reset();
    m_owner = -1;
    m_rr    = 0;
    m_tie   = 1'b0;
  endtask

  // One clock edge of ownership rules, from the current inputs.
  task automatic model_edge();
    int best, cnt, win, j;
    bit preempt;
    best = 0; cnt = 0; win = -1;
`ifdef STRENGTH_PREEMPT_EN
    preempt = 1'b1;
`else
    preempt = 1'b0;
`endif
    for (int i = 0; i < N; i++)
      if (is_cand(i) && effs(i) > best) best = effs(i);
    for (int i = 0; i < N; i++)
      if (is_cand(i) && effs(i) == best) cnt++;
    for (int k = 0; k < N; k++) begin
      j = (m_rr + k) % N;
      if (win < 0 && is_cand(j) && effs(j) == best) win = j;
    end
    m_tie = 1'b0;
    if (m_owner >= 0 && is_cand(m_owner)) begin
      if (preempt && best > effs(m_owner)) m_owner = -1;  // handover gap
    end else if (win >= 0) begin
      m_owner = win;
      m_rr    = (win + 1) % N;
      m_tie   = (cnt > 1);
    end else begin
      m_owner = -1;
    end
  endtask

  task automatic chk(string tag, logic [127:0] got, logic [127:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic check_all(string tag);
    logic [N-1:0] eg;
    logic [W-1:0] eo;
    eg = '0;
    eo = DEF;
    if (m_owner >= 0) begin
      eg[m_owner] = 1'b1;
      eo = bus_if.data[m_owner*W +: W];
    end
    chk({tag, ".grant"}, 128'(bus_if.grant), 128'(eg));
    chk({tag, ".valid"}, 128'(bus_if.bus_valid), 128'(m_owner >= 0));
    chk({tag, ".bus_out"}, 128'(bus_if.bus_out), 128'(eo));
    chk({tag, ".strength"}, 128'(bus_if.bus_strength),
        128'((m_owner >= 0) ? effs(m_owner) : 1));
    chk({tag, ".tie"}, 128'(bus_if.tie), 128'(m_tie));
  endtask

  // Advance one edge in model and DUT, then compare away from the edge.
  task automatic step(string tag);
    if (rst) model_reset();
    else     model_edge();
    @(posedge clk);
    #1;
    check_all(tag);
  endtask

  task automatic set_req(int i, bit r, int s, logic [W-1:0] d);
    bus_if.req[i]            = r;
    bus_if.strength[i*3 +: 3] = 3'(s);
    bus_if.data[i*W +: W]    = d;
  endtask

  initial begin
    tests = 0;
    fails = 0;
    model_reset();
    rst = 1'b1;
    bus_if.req      = '0;
    bus_if.strength = '0;
    bus_if.data     = '0;
    @(negedge clk);

    // 1: reset, then idle.
    step("reset");
    rst = 1'b0;
    for (int c = 0; c < 5; c++) step("idle");

    // 2/4: weak owner, then a strong contender; then the weak owner leaves.
    set_req(0, 1'b1, 1, W'(1));
    step("weak_own");
    chk("weak_own.lit", 128'(bus_if.grant), 128'(4'b0001));
    set_req(1, 1'b1, 3, W'(5));
    step("contend0");
    step("contend1");
    step("contend2");
    set_req(0, 1'b0, 1, W'(1));
    step("weak_drop");
    chk("strong_own.lit", 128'(bus_if.grant), 128'(4'b0010));
    chk("strong_out.lit", 128'(bus_if.bus_out), 128'(5));
    bus_if.req = '0;
    step("clear2");

    // 3: four equal strong requesters, each drops once granted.
    rst = 1'b1;
    step("rst3");
    rst = 1'b0;
    for (int i = 0; i < N; i++) set_req(i, 1'b1, 3, W'(i + 16));
    for (int i = 0; i < N; i++) begin
      step("rr_chain");
      chk("rr_chain.lit", 128'(bus_if.grant), 128'(1 << i));
      chk("rr_tie.lit", 128'(bus_if.tie), 128'(i < 3));
      bus_if.req[i] = 1'b0;
    end
    step("clear3");

    // 5: strength 0 never competes; supply levels collapse to 4.
    set_req(0, 1'b1, 0, W'(7));
    set_req(1, 1'b1, 2, W'(9));
    step("zero_str");
    chk("zero_str.lit", 128'(bus_if.grant), 128'(4'b0010));
    bus_if.strength[3 +: 3] = 3'd6;
    step("supply");
    chk("supply.lit", 128'(bus_if.bus_strength), 128'(4));

    // 6: reset mid-ownership clears rr_ptr.
    rst = 1'b1;
    step("mid_rst");
    chk("mid_rst.lit", 128'(bus_if.grant), 128'(0));
    rst = 1'b0;
    set_req(0, 1'b1, 3, W'(11));
    set_req(1, 1'b1, 3, W'(12));
    step("post_rst");
    chk("post_rst.lit", 128'(bus_if.grant), 128'(4'b0001));

    // Randomized traffic.
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if ($urandom_range(0, 3) == 0) bus_if.req[i] = ~bus_if.req[i];
        if ($urandom_range(0, 4) == 0) bus_if.strength[i*3 +: 3] = 3'($urandom_range(0, 7));
        if ($urandom_range(0, 2) == 0)
          bus_if.data[i*W +: W] = {4'($urandom), $urandom, $urandom, $urandom};
      end
      rst = ($urandom_range(0, 39) == 0);
      step("rand");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
